// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// The control bundle is ordered {pc, ifid, idex, exmem, memwb enables, ifid/idex flushes}.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        DMEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_BOOT     = 7'b00000_11;
    localparam ctrl_t CTRL_FREEZE   = 7'b00000_00;
    localparam ctrl_t CTRL_REDIRECT = 7'b11111_11;
    localparam ctrl_t CTRL_BUBBLE   = 7'b00111_01;
    localparam ctrl_t CTRL_FLOW     = 7'b11111_00;

    // A redirect squashes the ID instruction, so it masks any load-use hazard.
    function automatic ctrl_t resolve_ctrl(input logic redirect, input logic load_use);
        if (redirect) begin
            return CTRL_REDIRECT;
        end else if (load_use) begin
            return CTRL_BUBBLE;
        end
        return CTRL_FLOW;
    endfunction

endpackage

// File: rtl/hazard_ctrl_pipe_if.sv
// Hazard-controller bundle. Pipeline status flows into the controller and enables/flushes
// flow out; master is the controller side, slave is the pipeline side.
import pipe_ctrl_pkg::*;

interface hazard_ctrl_pipe_if;
    reg_idx_t    id_rs1;
    reg_idx_t    id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_mem_read;
    reg_idx_t    ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        dmem_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
    hz_state_t   state;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_redirect, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               dmem_timeout, perf_stall_cycles, perf_flushes, state
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_redirect, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               dmem_timeout, perf_stall_cycles, perf_flushes, state
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads the register a load in EX
// is about to write. x0 is hard-wired and never creates a dependency.
import pipe_ctrl_pkg::*;

module load_use_detect (
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  logic     use_rs1,
    input  logic     use_rs2,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    output logic     hazard
);
    logic match_rs1;
    logic match_rs2;

    assign match_rs1 = use_rs1 && (rs1 == ex_rd);
    assign match_rs2 = use_rs2 && (rs2 == ex_rd);
    assign hazard    = ex_mem_read && (ex_rd != '0) && (match_rs1 || match_rs2);
endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Pipeline hazard and stall controller: boot hold, load-use bubbles, redirect squash,
// data-memory freeze, plus stall/flush counters and a sticky data-memory timeout flag.
import pipe_ctrl_pkg::*;

module hazard_ctrl_pipe #(
    parameter int BOOT_CYCLES  = 4,
    parameter int DMEM_TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst,
    hazard_ctrl_pipe_if.master bus
);
    localparam logic [31:0] BOOT_LAST   = (BOOT_CYCLES > 0) ? 32'(BOOT_CYCLES - 1) : 32'd0;
    localparam logic [31:0] TIMEOUT_LIM = 32'(DMEM_TIMEOUT);

    hz_state_t   state;
    logic [31:0] boot_cnt;
    logic [31:0] wait_cnt;
    logic [31:0] wait_next;
    logic        timeout;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic        load_use;
    logic        mem_blocked;
    logic        resolving;
    logic        count_stall;
    logic        count_flush;
    ctrl_t       ctrl;

    load_use_detect u_load_use (
        .rs1         (bus.id_rs1),
        .rs2         (bus.id_rs2),
        .use_rs1     (bus.id_use_rs1),
        .use_rs2     (bus.id_use_rs2),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .hazard      (load_use)
    );

    assign mem_blocked = bus.mem_req && !bus.mem_ready;
    assign wait_next   = (wait_cnt == '1) ? wait_cnt : wait_cnt + 32'd1;

    // Controls are combinational so a hazard acts on the very next edge.
    always_comb begin
        ctrl      = CTRL_BOOT;
        resolving = 1'b0;
        case (state)
            BOOT: begin
                ctrl = CTRL_BOOT;
            end
            RUN: begin
                if (mem_blocked) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl      = resolve_ctrl(bus.ex_redirect, load_use);
                    resolving = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (bus.mem_ready) begin
                    ctrl      = resolve_ctrl(bus.ex_redirect, load_use);
                    resolving = 1'b1;
                end else begin
                    ctrl = CTRL_FREEZE;
                end
            end
            default: begin
                ctrl = CTRL_BOOT;
            end
        endcase
    end

    assign count_stall = (state != BOOT) && !ctrl.pc_en;
    assign count_flush = resolving && bus.ex_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (count_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (count_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 32'd1;
                    if (boot_cnt >= BOOT_LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_blocked) begin
                        state <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        // The FSM keeps waiting after a timeout; only the flag records it.
                        wait_cnt <= wait_next;
                        if (wait_next >= TIMEOUT_LIM) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign bus.pc_en             = ctrl.pc_en;
    assign bus.ifid_en           = ctrl.ifid_en;
    assign bus.idex_en           = ctrl.idex_en;
    assign bus.exmem_en          = ctrl.exmem_en;
    assign bus.memwb_en          = ctrl.memwb_en;
    assign bus.ifid_flush        = ctrl.ifid_flush;
    assign bus.idex_flush        = ctrl.idex_flush;
    assign bus.dmem_timeout      = timeout;
    assign bus.perf_stall_cycles = stall_cnt;
    assign bus.perf_flushes      = flush_cnt;
    assign bus.state             = state;
endmodule
